// File: rtl/deser_pkg.sv
// ----------------------------------------------------------------------------
// deser_pkg
//   Shared types and constants for the serial word deserializer.
//   - bit_order_t : per-word bit order (MSB-first / LSB-first)
//   - cnt_width() : width of a counter that indexes 0..w-1, never below 1 bit
// ----------------------------------------------------------------------------
package deser_pkg;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_t;

  // $clog2(2) is 1, but $clog2(1) would be 0; clamp so the counter always
  // has at least one bit.
  function automatic int cnt_width(input int w);
    if (w <= 2) begin
      return 1;
    end
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_deserializer_bit_reverse.sv
// ----------------------------------------------------------------------------
// bit_reverse
//   Purely combinational bit-order swap: out_o[i] = in_i[DATA_WIDTH-1-i].
//   Ports:
//     in_i  [DATA_WIDTH-1:0]  word as assembled MSB-first
//     out_o [DATA_WIDTH-1:0]  the same word with its bit order reversed
// ----------------------------------------------------------------------------
module bit_reverse #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic [DATA_WIDTH-1:0] out_o
);

  always_comb begin
    out_o = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      out_o[i] = in_i[DATA_WIDTH-1-i];
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// ----------------------------------------------------------------------------
// serial_word_deserializer
//   Assembles a 1-bit serial stream into DATA_WIDTH-bit words. The bit order
//   (MSB-first or LSB-first) is latched from lsb_first on the first bit of each
//   word. Completed words sit in a one-entry output register drained through a
//   valid/ready handshake.
//
//   Handshake rules (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. The sender holds its data stable while valid
//   is high and ready is low. Here din_ready only drops while the final bit of
//   a word is pending and the output register is still occupied.
//
//   Ports:
//     clk         rising-edge clock
//     resetn      synchronous active-low reset
//     din         serial data bit
//     din_valid   din carries a bit this cycle
//     din_ready   block accepts din this cycle (combinational)
//     lsb_first   bit order for the word being started (1 = LSB-first)
//     dout        assembled word (registered)
//     dout_valid  dout holds an unconsumed word (registered)
//     dout_ready  downstream consumes dout this cycle
// ----------------------------------------------------------------------------
module serial_word_deserializer
  import deser_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  lsb_first,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  localparam int            CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  bit_order_t            order_q, order_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic                  accept;
  logic                  drain;
  logic                  at_last;
  logic                  complete;
  logic [DATA_WIDTH-1:0] word_raw;
  logic [DATA_WIDTH-1:0] word_rev;
  logic [DATA_WIDTH-1:0] word_final;

  assign at_last = (cnt_q == CNT_LAST);
  assign drain   = dout_valid_q && dout_ready;

  // Only the final bit of a word can be blocked, and only when the output
  // register is full and not draining this very cycle. The dout_ready term
  // gives a combinational path to din_ready so a stalled final bit is taken
  // in the same cycle the pending word drains.
  assign din_ready = !(at_last && dout_valid_q && !dout_ready);
  assign accept    = din_valid && din_ready;
  assign complete  = accept && at_last;

  // Word as it would look after this cycle's shift; the first-received bit
  // lands in the MSB.
  assign word_raw = {sr_q[DATA_WIDTH-2:0], din};

  bit_reverse #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bit_reverse (
    .in_i (word_raw),
    .out_o(word_rev)
  );

  // order_q was captured on the word's first bit; DATA_WIDTH >= 2 guarantees
  // that happened in an earlier cycle than the completing bit.
  assign word_final = (order_q == LSB_FIRST) ? word_rev : word_raw;

  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    order_d      = order_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (accept) begin
      sr_d = word_raw;
      if (at_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      if (cnt_q == '0) begin
        order_d = bit_order_t'(lsb_first);
      end
    end

    // A completion in the same cycle as a drain simply replaces the word,
    // keeping dout_valid high.
    if (complete) begin
      dout_d       = word_final;
      dout_valid_d = 1'b1;
    end else if (drain) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      order_q      <= MSB_FIRST;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      order_q      <= order_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
